// File: rtl/regfile_wb_sequencer.sv
// Write-back sequencer for the single register-file write port.
// Merges ALU results and load data in age order, retires one write per cycle
// through a registered port, buffers deferred writes in a 2-entry FIFO and
// exposes pending writes to the operand-read path through a bypass.
module regfile_wb_sequencer #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [1:0]      wb_src,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_hit,
    output logic            rs2_hit,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [1:0]      pend_cnt
);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_LD   = 2'b10;
    localparam logic [1:0] SRC_FIFO = 2'b11;

    // FIFO storage: entry 0 is the head (oldest), entry 1 the second slot.
    logic [AW-1:0]   q_rd   [2];
    logic [XLEN-1:0] q_data [2];
    logic [1:0]      cnt;

    // Surviving requests of this cycle, compacted in age order.
    logic [AW-1:0]   c_rd   [4];
    logic [XLEN-1:0] c_data [4];
    logic [1:0]      c_src  [4];
    logic [2:0]      n;

    logic ld_live;
    logic alu_live;

    assign ld_live   = ld_valid && (ld_rd != '0);
    assign alu_ready = !((cnt == 2'd2) && ld_live);
    assign alu_live  = alu_valid && alu_ready && (alu_rd != '0);
    assign pend_cnt  = cnt;

    // Gather FIFO head, FIFO second slot, load, ALU into an age-ordered list.
    // The ready rule guarantees at most three survivors, so index 3 stays unused.
    always_comb begin
        n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            c_rd[i]   = '0;
            c_data[i] = '0;
            c_src[i]  = SRC_NONE;
        end
        if (cnt != 2'd0) begin
            c_rd[n[1:0]]   = q_rd[0];
            c_data[n[1:0]] = q_data[0];
            c_src[n[1:0]]  = SRC_FIFO;
            n              = n + 3'd1;
        end
        if (cnt == 2'd2) begin
            c_rd[n[1:0]]   = q_rd[1];
            c_data[n[1:0]] = q_data[1];
            c_src[n[1:0]]  = SRC_FIFO;
            n              = n + 3'd1;
        end
        if (ld_live) begin
            c_rd[n[1:0]]   = ld_rd;
            c_data[n[1:0]] = ld_data;
            c_src[n[1:0]]  = SRC_LD;
            n              = n + 3'd1;
        end
        if (alu_live) begin
            c_rd[n[1:0]]   = alu_rd;
            c_data[n[1:0]] = alu_data;
            c_src[n[1:0]]  = SRC_ALU;
            n              = n + 3'd1;
        end
    end

    // Oldest survivor goes to the write port; the next two refill the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            wb_src    <= SRC_NONE;
            cnt       <= '0;
            q_rd[0]   <= '0;
            q_rd[1]   <= '0;
            q_data[0] <= '0;
            q_data[1] <= '0;
        end else begin
            rf_we  <= (n != 3'd0);
            wb_src <= c_src[0];
            if (n != 3'd0) begin
                rf_waddr <= c_rd[0];
                rf_wdata <= c_data[0];
            end
            q_rd[0]   <= c_rd[1];
            q_data[0] <= c_data[1];
            q_rd[1]   <= c_rd[2];
            q_data[1] <= c_data[2];
            cnt       <= (n > 3'd1) ? 2'(n - 3'd1) : 2'd0;
        end
    end

    // Youngest pending write wins: FIFO tail, then head, then output register.
    function automatic logic [XLEN:0] lookup(
        input logic [AW-1:0]   a,
        input logic [1:0]      occ,
        input logic [AW-1:0]   rd0,
        input logic [XLEN-1:0] d0,
        input logic [AW-1:0]   rd1,
        input logic [XLEN-1:0] d1,
        input logic            we,
        input logic [AW-1:0]   wa,
        input logic [XLEN-1:0] wd
    );
        logic [XLEN:0] r;
        r = '0;
        if (a != '0) begin
            if ((occ == 2'd2) && (rd1 == a))      r = {1'b1, d1};
            else if ((occ != 2'd0) && (rd0 == a)) r = {1'b1, d0};
            else if (we && (wa == a))             r = {1'b1, wd};
        end
        return r;
    endfunction

    // Operand bypass for both read ports.
    always_comb begin
        {rs1_hit, rs1_data} = lookup(rs1_addr, cnt, q_rd[0], q_data[0], q_rd[1], q_data[1],
                                     rf_we, rf_waddr, rf_wdata);
        {rs2_hit, rs2_data} = lookup(rs2_addr, cnt, q_rd[0], q_data[0], q_rd[1], q_data[1],
                                     rf_we, rf_waddr, rf_wdata);
    end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Scoreboard bench for regfile_wb_sequencer: the driver pushes every accepted
// write, the monitor pops and compares on each rf_we, and directed checks cover
// reset, bypass priority, back-pressure and rd=0 handling.
module tb_regfile_wb_sequencer;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 1'b0;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            alu_ready;
    logic            ld_valid = 1'b0;
    logic [AW-1:0]   ld_rd = '0;
    logic [XLEN-1:0] ld_data = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [1:0]      wb_src;
    logic [AW-1:0]   rs1_addr = '0;
    logic [AW-1:0]   rs2_addr = '0;
    logic            rs1_hit, rs2_hit;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [1:0]      pend_cnt;

    regfile_wb_sequencer #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_src(wb_src),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_hit(rs1_hit), .rs2_hit(rs2_hit), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic [1:0]      src;
        int unsigned     stamp;
    } wb_t;

    wb_t         sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic        acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One cycle: drive at posedge+1, decide acceptance just before the edge,
    // return at posedge+1 of the following cycle.
    task automatic step(input logic lv, input logic [AW-1:0] lr, input logic [XLEN-1:0] ldv,
                        input logic av, input logic [AW-1:0] ar, input logic [XLEN-1:0] ad,
                        output logic a_acc);
        wb_t e;
        ld_valid = lv; ld_rd = lr; ld_data = ldv;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        @(negedge clk);
        a_acc = av && alu_ready;
        if (lv && lr != '0) begin
            e.rd = lr; e.data = ldv; e.src = 2'b10; e.stamp = cyc + 1;
            sb.push_back(e);
        end
        if (a_acc && ar != '0) begin
            e.rd = ar; e.data = ad; e.src = 2'b01; e.stamp = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic d;
        step(1'b0, '0, '0, 1'b0, '0, '0, d);
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (pend_cnt == 2'd0 && !rf_we) break;
            idle();
        end
        chk("drain_done", {62'd0, pend_cnt}, 64'd0);
    endtask

    // Monitor: every committed write must be the oldest expected one.
    initial begin
        wb_t e;
        logic [1:0] s;
        forever begin
            @(negedge clk);
            if (rst && rf_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {25'd0, rf_waddr, rf_wdata, wb_src}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    s = (cyc == e.stamp) ? e.src : 2'b11;
                    chk("sb_write", {25'd0, rf_waddr, rf_wdata, wb_src}, {25'd0, e.rd, e.data, s});
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rs1_addr = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("rst_src", {62'd0, wb_src}, 64'd0);
        chk("rst_pend", {62'd0, pend_cnt}, 64'd0);
        chk("rst_ready", {63'd0, alu_ready}, 64'd1);
        chk("rst_hit", {63'd0, rs1_hit}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU write, direct path
        step(1'b0, '0, '0, 1'b1, 5'd3, 32'h11, acc);
        chk("alu_we", {63'd0, rf_we}, 64'd1);
        chk("alu_waddr", {59'd0, rf_waddr}, 64'd3);
        chk("alu_wdata", {32'd0, rf_wdata}, 64'h11);
        chk("alu_src", {62'd0, wb_src}, 64'd1);
        chk("alu_pend", {62'd0, pend_cnt}, 64'd0);

        // Idle with empty FIFO
        idle();
        chk("idle_we", {63'd0, rf_we}, 64'd0);
        chk("idle_src", {62'd0, wb_src}, 64'd0);

        // Load and ALU to the same rd in one cycle
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        step(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, acc);
        chk("same_src_ld", {62'd0, wb_src}, 64'd2);
        chk("same_wdata_ld", {32'd0, rf_wdata}, 64'hAA);
        chk("same_pend", {62'd0, pend_cnt}, 64'd1);
        chk("same_rs1_hit", {63'd0, rs1_hit}, 64'd1);
        chk("same_rs1_data", {32'd0, rs1_data}, 64'hBB);
        chk("same_rs2_data", {32'd0, rs2_data}, 64'hBB);
        idle();
        chk("same_src_fifo", {62'd0, wb_src}, 64'd3);
        chk("same_wdata_fifo", {32'd0, rf_wdata}, 64'hBB);
        chk("same_pend_after", {62'd0, pend_cnt}, 64'd0);
        chk("out_rs1_hit", {63'd0, rs1_hit}, 64'd1);
        chk("out_rs1_data", {32'd0, rs1_data}, 64'hBB);
        idle();
        chk("stale_rs1_hit", {63'd0, rs1_hit}, 64'd0);

        // Bypass priority: FIFO head (rd7=3) beats output register (rd7=2)
        rs1_addr = 5'd7; rs2_addr = 5'd9;
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, acc);
        step(1'b1, 5'd7, 32'h3, 1'b1, 5'd9, 32'h4, acc);
        chk("prio_acc", {63'd0, acc}, 64'd1);
        chk("prio_pend", {62'd0, pend_cnt}, 64'd2);
        chk("prio_wdata", {32'd0, rf_wdata}, 64'h2);
        chk("prio_rs1_data", {32'd0, rs1_data}, 64'h3);
        chk("prio_rs2_hit", {63'd0, rs2_hit}, 64'd1);
        chk("prio_rs2_data", {32'd0, rs2_data}, 64'h4);
        drain();

        // Fill: back-pressure on the ALU when FIFO is full and a load arrives
        step(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, acc);
        step(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, acc);
        chk("fill_pend2", {62'd0, pend_cnt}, 64'd2);
        step(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106, acc);
        chk("fill_alu_stall", {63'd0, acc}, 64'd0);
        chk("fill_pend_hold", {62'd0, pend_cnt}, 64'd2);
        step(1'b0, '0, '0, 1'b1, 5'd6, 32'h106, acc);
        chk("fill_alu_retry", {63'd0, acc}, 64'd1);
        drain();

        // rd=0 requests are accepted and discarded
        rs1_addr = 5'd0;
        step(1'b1, 5'd0, 32'hEE, 1'b1, 5'd0, 32'hFF, acc);
        chk("rd0_acc", {63'd0, acc}, 64'd1);
        chk("rd0_we", {63'd0, rf_we}, 64'd0);
        chk("rd0_pend", {62'd0, pend_cnt}, 64'd0);
        chk("rd0_hit", {63'd0, rs1_hit}, 64'd0);

        // Asynchronous reset with a full FIFO
        rs1_addr = 5'd4;
        step(1'b1, 5'd1, 32'h201, 1'b1, 5'd2, 32'h202, acc);
        step(1'b1, 5'd3, 32'h203, 1'b1, 5'd4, 32'h204, acc);
        chk("mid_pend2", {62'd0, pend_cnt}, 64'd2);
        ld_valid = 1'b0; alu_valid = 1'b0;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("arst_we", {63'd0, rf_we}, 64'd0);
        chk("arst_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("arst_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("arst_src", {62'd0, wb_src}, 64'd0);
        chk("arst_pend", {62'd0, pend_cnt}, 64'd0);
        chk("arst_hit", {63'd0, rs1_hit}, 64'd0);
        chk("arst_ready", {63'd0, alu_ready}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) idle();
        chk("post_rst_we", {63'd0, rf_we}, 64'd0);
        chk("post_rst_pend", {62'd0, pend_cnt}, 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sequencer.md
# regfile_wb_sequencer

Write-back sequencer between the execute/load producers and the single register-file write port. It accepts ALU results and late-arriving load data, orders them, and commits them one per cycle through a registered write port. Deferred writes are buffered in a 2-entry FIFO and exposed to the operand-read path through a bypass. It is the consuming end of the write-source selection, driving the register file's write enable, address, data and source select.

## Interface
- XLEN, 32, data width
- AW, 5, register address width

- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU write-back request
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- ld_valid  in  1  load write-back request; always accepted, never stalled
- ld_rd  in  AW  load destination register
- ld_data  in  XLEN  load data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  write address (registered)
- rf_wdata  out  XLEN  write data (registered)
- wb_src  out  2  source of current write: 00 none, 01 ALU, 10 load, 11 FIFO (registered)
- rs1_addr, rs2_addr  in  AW  operand read addresses
- rs1_hit, rs2_hit  out  1  pending write matches address (combinational)
- rs1_data, rs2_data  out  XLEN  bypass data, valid when hit
- pend_cnt  out  2  FIFO occupancy 0..2

## Operation
- Accepted request = valid && ready (ld always ready). Request with rd==0: accepted, then discarded — never written, enqueued or bypassed.
- Age order per cycle: FIFO head, FIFO tail, load, ALU (load is older than a same-cycle ALU result).
- Port selection: oldest surviving request goes to the output register; remaining surviving new requests are pushed to FIFO in age order (load before ALU).
- FIFO pop and push in the same cycle are allowed; capacity for new requests = 3 − pend_cnt.
- alu_ready = !(pend_cnt==2 && ld_valid && ld_rd!=0); otherwise 1.
- No request is ever dropped; accepted writes reach the register file in age order, so the last write to a given rd wins.
- Bypass for rsN: match rsN_addr (≠0) against FIFO tail, FIFO head, output register (when rf_we), in that priority; youngest match drives rsN_data. Same-cycle inputs are not bypassed.

## Timing
- Reset (rst low, async): rf_we=0, rf_waddr=0, rf_wdata=0, wb_src=00, FIFO empty, pend_cnt=0, hits 0. alu_ready=1 during reset.
- Latency: request arriving with empty FIFO appears on rf_* the next cycle; FIFO-queued entries retire one per cycle.
- rf_we=0 and wb_src=00 in any cycle with no surviving request.
- Reset asserted mid-operation: FIFO contents and output register discarded immediately; no partial writes after release.
- First posedge after rst release behaves as idle with empty FIFO.

## Test plan
- Reset then ALU rd=3 data=0x11 -> next cycle rf_we=1, waddr=3, wdata=0x11, wb_src=01; pend_cnt=0.
- Load rd=5 0xAA and ALU rd=5 0xBB same cycle, FIFO empty -> cycle+1 writes 5←0xAA (src 10), cycle+2 writes 5←0xBB (src 11); rs1_addr=5 at cycle+1 gives hit, data 0xBB.
- Fill: load+ALU every cycle for 3 cycles -> pend_cnt reaches 2; with pend_cnt=2 and ld_valid, alu_ready=0; no write lost, order verified against scoreboard.
- ALU rd=0 data=0xFF -> rf_we stays 0, pend_cnt unchanged, rs1_addr=0 gives no hit.
- Assert rst with pend_cnt=2 -> all outputs return to reset values asynchronously; after release, no queued write appears.
- Idle cycle with empty FIFO -> rf_we=0, wb_src=00.
